// File: rtl/varredura_matriz_pkg.sv
// varredura_matriz_pkg
//   Shared constants for the LED matrix scanner: output polarities, default
//   geometry/timing values and a width helper.
//   Optional feature macro used by the design: MATRIZ_PISCAR_EN (per-pixel blink).
//   No ports (package).
package varredura_matriz_pkg;

  // Output polarities: rows drive high to light, columns are selected low.
  localparam logic LINHA_ATIVA  = 1'b1;
  localparam logic COLUNA_ATIVA = 1'b0;

  // Default parameter values.
  localparam int LINHAS_PADRAO         = 7;
  localparam int COLUNAS_PADRAO        = 5;
  localparam int DIV_VARREDURA_PADRAO  = 64;
  localparam int QUADROS_PISCAR_PADRAO = 32;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/varredura_matriz_contador.sv
// contador_varredura
//   Scan timebase: a prescaler counting 0..DIV_VARREDURA-1 and a column index
//   counting 0..COLUNAS-1 that advances on every prescaler wrap.
//   Ports:
//     clock, reset   - rising-edge clock, asynchronous active-high reset
//     coluna         - current column index (registered)
//     fim_quadro     - registered strobe, high exactly while the prescaler is
//                      at DIV_VARREDURA-1 and the column is COLUNAS-1
module contador_varredura
  import varredura_matriz_pkg::*;
#(
  parameter int COLUNAS       = COLUNAS_PADRAO,
  parameter int DIV_VARREDURA = DIV_VARREDURA_PADRAO,
  localparam int PW = largura(DIV_VARREDURA),
  localparam int CW = largura(COLUNAS)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [CW-1:0] coluna,
  output logic          fim_quadro
);

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_VARREDURA - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLUNAS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] col_q, col_d;
  logic          fim_q, fim_d;
  logic          wrap;

  always_comb begin
    wrap    = (presc_q == PRESC_MAX);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    col_d   = col_q;
    if (wrap) begin
      col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
    end
    // Decoded from the next state so the strobe is a flop yet lines up with
    // the last prescaler cycle of the last column.
    fim_d = (presc_d == PRESC_MAX) && (col_d == COL_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      col_q   <= '0;
      fim_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      col_q   <= col_d;
      fim_q   <= fim_d;
    end
  end

  assign coluna     = col_q;
  assign fim_quadro = fim_q;

endmodule

// File: rtl/varredura_matriz.sv
// varredura_matriz
//   Multiplexed LED matrix driver. An image (mapa) and blink mask (piscar) are
//   captured into a pending buffer on atualizar, promoted to the display buffer
//   at each frame boundary, and scanned out one column at a time.
//   Optional feature: define MATRIZ_PISCAR_EN to build the blink counter,
//   blink phase and piscar buffers; without it piscar is ignored.
//   Ports:
//     clock, reset  - rising-edge clock, asynchronous active-high reset
//     enable        - 1 drives the matrix, 0 blanks it (scan keeps running)
//     mapa, piscar  - image and blink mask, bit c*LINHAS+r = row r of column c
//     atualizar     - one-cycle pulse capturing mapa/piscar
//     linhas        - row data of the active column (active-high, registered)
//     colunas       - one-hot column select (active-low, registered)
//     fim_quadro    - one-cycle pulse at the end of the last column's dwell
module varredura_matriz
  import varredura_matriz_pkg::*;
#(
  parameter int LINHAS         = LINHAS_PADRAO,
  parameter int COLUNAS        = COLUNAS_PADRAO,
  parameter int DIV_VARREDURA  = DIV_VARREDURA_PADRAO,
  parameter int QUADROS_PISCAR = QUADROS_PISCAR_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [LINHAS*COLUNAS-1:0] mapa,
  input  logic [LINHAS*COLUNAS-1:0] piscar,
  input  logic                      atualizar,
  output logic [LINHAS-1:0]         linhas,
  output logic [COLUNAS-1:0]        colunas,
  output logic                      fim_quadro
);

  localparam int N  = LINHAS * COLUNAS;
  localparam int CW = largura(COLUNAS);

  logic [CW-1:0] coluna;
  logic          fim;

  contador_varredura #(
    .COLUNAS       (COLUNAS),
    .DIV_VARREDURA (DIV_VARREDURA)
  ) u_contador (
    .clock      (clock),
    .reset      (reset),
    .coluna     (coluna),
    .fim_quadro (fim)
  );

  logic [N-1:0] pend_mapa_q, pend_mapa_d;
  logic [N-1:0] disp_mapa_q, disp_mapa_d;
  logic [N-1:0] visivel;

  // The display buffer takes the pending value as it stood before the
  // boundary edge, so a capture on that same edge waits one more frame.
  always_comb begin
    pend_mapa_d = atualizar ? mapa : pend_mapa_q;
    disp_mapa_d = fim ? pend_mapa_q : disp_mapa_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_mapa_q <= '0;
      disp_mapa_q <= '0;
    end else begin
      pend_mapa_q <= pend_mapa_d;
      disp_mapa_q <= disp_mapa_d;
    end
  end

`ifdef MATRIZ_PISCAR_EN
  localparam logic [7:0] QUADRO_MAX = 8'(QUADROS_PISCAR - 1);

  logic [N-1:0] pend_pisc_q, pend_pisc_d;
  logic [N-1:0] disp_pisc_q, disp_pisc_d;
  logic [7:0]   quadro_q, quadro_d;
  logic         fase_q, fase_d;

  always_comb begin
    pend_pisc_d = atualizar ? piscar : pend_pisc_q;
    disp_pisc_d = fim ? pend_pisc_q : disp_pisc_q;
    quadro_d    = quadro_q;
    fase_d      = fase_q;
    if (fim) begin
      if (quadro_q == QUADRO_MAX) begin
        quadro_d = '0;
        fase_d   = ~fase_q;
      end else begin
        quadro_d = quadro_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_pisc_q <= '0;
      disp_pisc_q <= '0;
      quadro_q    <= '0;
      fase_q      <= 1'b0;
    end else begin
      pend_pisc_q <= pend_pisc_d;
      disp_pisc_q <= disp_pisc_d;
      quadro_q    <= quadro_d;
      fase_q      <= fase_d;
    end
  end

  // Blinking pixels go dark while the phase is 1.
  assign visivel = disp_mapa_q & ~(disp_pisc_q & {N{fase_q}});
`else
  logic unused_piscar;
  localparam int unused_quadros = QUADROS_PISCAR;
  assign unused_piscar = ^piscar;
  assign visivel       = disp_mapa_q;
`endif

  logic [LINHAS-1:0]  aceso;
  logic [LINHAS-1:0]  linhas_q, linhas_d;
  logic [COLUNAS-1:0] colunas_q, colunas_d;

  // Row data and column select are both taken from the same column index and
  // registered together, so a column never sees another column's data.
  always_comb begin
    aceso     = '0;
    colunas_d = {COLUNAS{~COLUNA_ATIVA}};
    for (int c = 0; c < COLUNAS; c++) begin
      if (coluna == CW'(c)) begin
        aceso = visivel[c*LINHAS +: LINHAS];
        if (enable) colunas_d[c] = COLUNA_ATIVA;
      end
    end
    linhas_d = enable ? (aceso ^ {LINHAS{~LINHA_ATIVA}}) : {LINHAS{~LINHA_ATIVA}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      linhas_q  <= {LINHAS{~LINHA_ATIVA}};
      colunas_q <= {COLUNAS{~COLUNA_ATIVA}};
    end else begin
      linhas_q  <= linhas_d;
      colunas_q <= colunas_d;
    end
  end

  assign linhas     = linhas_q;
  assign colunas    = colunas_q;
  assign fim_quadro = fim;

endmodule

// File: tb/tb_varredura_matriz.sv
// tb_varredura_matriz
//   Bench for varredura_matriz: a 7x5 instance (DIV 64, blink every 2 frames)
//   and an 8x8 instance (DIV 4). A frame-position model predicts every output
//   each cycle; a few literal expectations pin that model. Honours
//   MATRIZ_PISCAR_EN when the build defines it.
module tb_varredura_matriz;

  localparam int L  = 7;
  localparam int C  = 5;
  localparam int D  = 64;
  localparam int QP = 2;
  localparam int FR = C * D;
  localparam int N  = L * C;
  localparam int W  = L + C + 1;

  localparam int L2  = 8;
  localparam int C2  = 8;
  localparam int D2  = 4;
  localparam int FR2 = C2 * D2;
  localparam int N2  = L2 * C2;
  localparam int W2  = L2 + C2 + 1;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic atualizar = 1'b0;
  logic [N-1:0] mapa = '0;
  logic [N-1:0] piscar = '0;
  logic [L-1:0] linhas;
  logic [C-1:0] colunas;
  logic         fim_quadro;

  logic enable2 = 1'b1;
  logic atu2 = 1'b0;
  logic [N2-1:0] mapa2 = '0;
  logic [N2-1:0] piscar2 = '0;
  logic [L2-1:0] linhas2;
  logic [C2-1:0] colunas2;
  logic          fim2;

  always #5 clock = ~clock;

  varredura_matriz #(
    .LINHAS(L), .COLUNAS(C), .DIV_VARREDURA(D), .QUADROS_PISCAR(QP)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .mapa(mapa), .piscar(piscar),
    .atualizar(atualizar), .linhas(linhas), .colunas(colunas), .fim_quadro(fim_quadro)
  );

  varredura_matriz #(
    .LINHAS(L2), .COLUNAS(C2), .DIV_VARREDURA(D2), .QUADROS_PISCAR(32)
  ) dut2 (
    .clock(clock), .reset(reset), .enable(enable2), .mapa(mapa2), .piscar(piscar2),
    .atualizar(atu2), .linhas(linhas2), .colunas(colunas2), .fim_quadro(fim2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, m_k);
    end
  endtask

  // Model: frame position since reset release, pending/display images.
  int m_k = 0;
  int m_p, m_col, m_f, m_p2, m_col2;
  logic m_fase;
  logic [N-1:0]  m_pend_m, m_pend_p, m_disp_m, m_disp_p;
  logic [N2-1:0] m2_pend, m2_disp;
  logic [L-1:0]  m_lin;
  logic [C-1:0]  m_colu;
  logic [L2-1:0] m_lin2;
  logic [C2-1:0] m_colu2;
  logic [W-1:0]  exp_q[$];
  logic [W2-1:0] exp2_q[$];
  logic [W-1:0]  e;
  logic [W2-1:0] e2;

  task automatic model_clear();
    m_k = 0;
    m_pend_m = '0; m_pend_p = '0; m_disp_m = '0; m_disp_p = '0;
    m2_pend = '0; m2_disp = '0;
    exp_q.delete();
    exp2_q.delete();
  endtask

  always begin
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      // Outputs after this edge reflect the scan position before it.
      m_p   = m_k % FR;
      m_col = m_p / D;
      m_f   = m_k / FR;
`ifdef MATRIZ_PISCAR_EN
      m_fase = ((m_f / QP) % 2) == 1;
`else
      m_fase = 1'b0;
`endif
      m_lin  = '0;
      m_colu = '1;
      if (enable) begin
        for (int r = 0; r < L; r++)
          m_lin[r] = m_disp_m[m_col*L + r] & ~(m_disp_p[m_col*L + r] & m_fase);
        m_colu[m_col] = 1'b0;
      end
      exp_q.push_back({m_lin, m_colu, (((m_k + 1) % FR) == FR - 1)});
      if (m_p == FR - 1) begin
        m_disp_m = m_pend_m;
        m_disp_p = m_pend_p;
      end
      if (atualizar) begin
        m_pend_m = mapa;
        m_pend_p = piscar;
      end

      m_p2    = m_k % FR2;
      m_col2  = m_p2 / D2;
      m_lin2  = '0;
      m_colu2 = '1;
      if (enable2) begin
        for (int r = 0; r < L2; r++) m_lin2[r] = m2_disp[m_col2*L2 + r];
        m_colu2[m_col2] = 1'b0;
      end
      exp2_q.push_back({m_lin2, m_colu2, (((m_k + 1) % FR2) == FR2 - 1)});
      if (m_p2 == FR2 - 1) m2_disp = m2_pend;
      if (atu2) m2_pend = mapa2;

      m_k++;
    end

    @(negedge clock);
    if (reset) begin
      exp_q.delete();
      exp2_q.delete();
      check("rst_linhas", 64'(linhas), 64'(0));
      check("rst_colunas", 64'(colunas), 64'(5'b11111));
      check("rst_fim", 64'(fim_quadro), 64'(0));
      check("rst_linhas2", 64'(linhas2), 64'(0));
      check("rst_colunas2", 64'(colunas2), 64'(8'hff));
    end else if (exp_q.size() == 0 || exp2_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got %0d/%0d entries expected 1", exp_q.size(), exp2_q.size());
    end else begin
      e  = exp_q.pop_front();
      e2 = exp2_q.pop_front();
      check("linhas", 64'(linhas), 64'(e[W-1:C+1]));
      check("colunas", 64'(colunas), 64'(e[C:1]));
      check("fim_quadro", 64'(fim_quadro), 64'(e[0]));
      check("linhas2", 64'(linhas2), 64'(e2[W2-1:C2+1]));
      check("colunas2", 64'(colunas2), 64'(e2[C2:1]));
      check("fim2", 64'(fim2), 64'(e2[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Returns just after the negedge where the model has seen t edges.
  task automatic wait_k(input int t);
    int n;
    n = 0;
    while (m_k != t && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (m_k != t) begin
      checks++;
      failures++;
      $display("FAIL wait_k: got cycle %0d expected %0d", m_k, t);
    end
    #1;
  endtask

  task automatic pulse_atu(input logic [N-1:0] m, input logic [N-1:0] p);
    atualizar = 1'b1;
    mapa      = m;
    piscar    = p;
    @(negedge clock);
    #1;
    atualizar = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_n();
    return N'({$urandom, $urandom});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of stimulus expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int tgt;
  int fb;

  initial begin
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;

    // Reset release: column 0 first, image blank; load all-ones images.
    wait_k(1);
    check("first_col", 64'(colunas), 64'(5'b11110));
    check("first_blank", 64'(linhas), 64'(0));
    atu2  = 1'b1;
    mapa2 = 64'h8040201008040201;
    pulse_atu('1, '1);
    atu2  = 1'b0;

    wait_k(31);
    check("fim2_first", 64'(fim2), 64'(1));
    wait_k(40);
    check("layout2_lin", 64'(linhas2), 64'(8'h02));
    check("layout2_col", 64'(colunas2), 64'(8'b11111101));
    wait_k(63);
    check("fim2_second", 64'(fim2), 64'(1));
    wait_k(65);
    check("second_col", 64'(colunas), 64'(5'b11101));
    wait_k(319);
    check("fim_first", 64'(fim_quadro), 64'(1));
    wait_k(320);
    check("fim_after", 64'(fim_quadro), 64'(0));
    wait_k(330);
    check("frame1_lit", 64'(linhas), 64'(7'h7f));
    wait_k(650);
`ifdef MATRIZ_PISCAR_EN
    check("blink_dark", 64'(linhas), 64'(0));
`else
    check("no_blink_lit", 64'(linhas), 64'(7'h7f));
`endif

    // Mid-frame update: old image holds until the boundary.
    wait_k(1380);
    pulse_atu(N'(1), '0);
    wait_k(1500);
    check("old_image_holds", 64'(linhas), 64'(7'h7f));
    wait_k(1610);
    check("bit0_col0", 64'(linhas), 64'(7'b0000001));
    check("bit0_col0_sel", 64'(colunas), 64'(5'b11110));
    wait_k(1700);
    check("bit0_col1", 64'(linhas), 64'(0));

    // Update coinciding with the boundary.
    wait_k(1970);
    pulse_atu({C{7'b0000010}}, '0);
    wait_k(2239);
    check("fim_coincide", 64'(fim_quadro), 64'(1));
    pulse_atu(rand_n(), rand_n());
    wait_k(2260);
    check("pending_before_edge", 64'(linhas), 64'(7'b0000010));

    // Blanking for 100 cycles.
    wait_k(2700);
    enable = 1'b0;
    wait_k(2750);
    check("blank_col", 64'(colunas), 64'(5'b11111));
    check("blank_lin", 64'(linhas), 64'(0));
    wait_k(2800);
    enable = 1'b1;

    // Randomized updates and enable toggles.
    tgt = 2900;
    for (int i = 0; i < 40; i++) begin
      tgt = tgt + int'($urandom_range(150, 20));
      wait_k(tgt);
      case ($urandom_range(3, 0))
        0: pulse_atu(rand_n(), rand_n());
        1: enable = ~enable;
        2: begin
          atu2  = 1'b1;
          mapa2 = {$urandom, $urandom};
          @(negedge clock);
          #1;
          atu2 = 1'b0;
        end
        default: ;
      endcase
    end
    enable = 1'b1;
    pulse_atu(rand_n(), '0);

    // Reset mid-frame at column 3 discards pending data.
    fb = ((m_k / FR) + 2) * FR;
    wait_k(fb + 3*D + 10);
    check("col3_before_rst", 64'(colunas), 64'(5'b10111));
    pulse_atu(rand_n(), '0);
    reset = 1'b1;
    #1;
    check("rst_now_col", 64'(colunas), 64'(5'b11111));
    check("rst_now_lin", 64'(linhas), 64'(0));
    check("rst_now_fim", 64'(fim_quadro), 64'(0));
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    wait_k(1);
    check("restart_col0", 64'(colunas), 64'(5'b11110));
    wait_k(400);
    check("restart_blank", 64'(linhas), 64'(0));
    wait_k(450);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
